// File: rtl/layer0_input_packer_pkg.sv
// Shared constants, state encoding and the feature quantisation function for
// the layer-0 input packer and its testbench model.
package layer0_input_packer_pkg;

  localparam int NUM_FEATURES = 32;
  localparam int IN_W         = 16;
  localparam int Q_BITS       = 2;
  localparam int FRAC_SHIFT   = 10;

  localparam int VEC_W = NUM_FEATURES * Q_BITS;
  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int Q_MAX = 2 ** (Q_BITS - 1) - 1;
  localparam int Q_MIN = -(2 ** (Q_BITS - 1));

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    DISCARD
  } state_e;

  // Shift to the code scale, saturate, then offset into unsigned binary.
  function automatic logic [Q_BITS-1:0] quantize(input logic signed [IN_W-1:0] feature);
    int shifted;
    int clamped;
    shifted = int'(feature >>> FRAC_SHIFT);
    if (shifted > Q_MAX)      clamped = Q_MAX;
    else if (shifted < Q_MIN) clamped = Q_MIN;
    else                      clamped = shifted;
    return Q_BITS'(clamped - Q_MIN);
  endfunction

endpackage

// File: rtl/layer0_input_packer_quantizer.sv
// Purely combinational quantiser: one signed feature in, one offset-binary code out.
module layer0_feature_quantizer
  import layer0_input_packer_pkg::*;
(
  input  logic [IN_W-1:0]   feature_i,
  output logic [Q_BITS-1:0] code_o
);

  assign code_o = quantize(feature_i);

endmodule

// File: rtl/layer0_input_packer.sv
// Collects one quantised feature per beat into a shadow buffer and presents the
// completed vector to layer 0, dropping frames whose length is wrong.
module layer0_input_packer
  import layer0_input_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [VEC_W-1:0]   shadow_q;
  logic [VEC_W-1:0]   shadow_d;
  logic [VEC_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               frame_err_q;
  logic [15:0]        frame_cnt_q;
  logic [Q_BITS-1:0]  code;
  logic               beat;
  logic               at_last_slot;

  layer0_feature_quantizer u_quant (
    .feature_i (in_data),
    .code_o    (code)
  );

  assign in_ready     = (state_q != FULL);
  assign beat         = in_valid & in_ready;
  assign at_last_slot = (idx_q == IDX_W'(NUM_FEATURES - 1));

  // Buffer with the current beat merged in, so the final beat lands in out_data directly.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[idx_q*Q_BITS +: Q_BITS] = code;
  end

  // NOTE: the shadow buffer carries no reset; every slot is rewritten before a
  // frame can complete, so stale contents never reach out_data.
  always_ff @(posedge clk) begin
    if (beat && state_q == COLLECT) shadow_q <= shadow_d;
  end

  // NOTE: sequential state uses non-blocking assignment only, so every branch
  // below sees the pre-edge value of each register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (beat) begin
            if (!at_last_slot) begin
              if (in_last) begin
                frame_err_q <= 1'b1;
                idx_q       <= '0;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              idx_q <= '0;
              if (in_last) begin
                out_data_q  <= shadow_d;
                out_valid_q <= 1'b1;
                state_q     <= FULL;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= DISCARD;
              end
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= COLLECT;
          end
        end
        DISCARD: begin
          if (beat && in_last) begin
            idx_q   <= '0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/layer0_input_packer.md
Name: layer0_input_packer

Overview:
- Upstream stage of the layer-0 LogicNets neuron array; produces the packed, quantised feature vector that all layer-0 neuron LUTs slice their 6-bit inputs from.
- Accepts one signed readout feature per beat on a valid/ready stream and quantises each feature to Q_BITS.
- Packs NUM_FEATURES codes into one vector and holds it registered until layer 0 accepts it.
- Detects frame-length errors and resynchronises on in_last.

Parameters:
- NUM_FEATURES, 32, features per frame (≥2).
- IN_W, 16, signed input feature width.
- Q_BITS, 2, quantised code width per feature (1..4).
- FRAC_SHIFT, 10, arithmetic right-shift applied before clamping (< IN_W).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  IN_W  signed feature.
- in_last  in  1  marks the last feature of a frame.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  layer 0 accepts the vector.
- out_data  out  NUM_FEATURES*Q_BITS  packed codes; feature k is at [k*Q_BITS +: Q_BITS].
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- frame_cnt  out  16  count of vectors delivered; wraps at 2^16.

Behaviour:
- Reset (async, rst=1): state=COLLECT, beat index idx=0, out_valid=0, out_data=0, frame_err=0, frame_cnt=0. in_ready is 1 after reset.
- Quantisation (combinational on in_data):
  - s = in_data >>> FRAC_SHIFT (arithmetic shift).
  - Clamp s to [-(2^(Q_BITS-1)), 2^(Q_BITS-1)-1].
  - code = clamped + 2^(Q_BITS-1), unsigned offset binary. For Q_BITS=2: -2→00, -1→01, 0→10, 1→11.
- A beat transfers when in_valid & in_ready. Transferred beats write their code into slot idx of a shadow buffer.
- State COLLECT (in_ready=1):
  - Beat with idx<NUM_FEATURES-1 and in_last=0: idx++.
  - Beat with idx<NUM_FEATURES-1 and in_last=1 (short frame): drop the shadow buffer, pulse frame_err next cycle, idx=0, stay in COLLECT.
  - Beat with idx==NUM_FEATURES-1 and in_last=1: on the next edge, copy the shadow buffer including this code into out_data, set out_valid=1, idx=0, go to FULL.
  - Beat with idx==NUM_FEATURES-1 and in_last=0 (long frame): pulse frame_err, idx=0, go to DISCARD.
- State DISCARD (in_ready=1): consume and ignore beats. A beat with in_last=1 returns to COLLECT with idx=0. No further frame_err pulses.
- State FULL (in_ready=0): out_data and out_valid stay stable.
  - On out_valid & out_ready: out_valid=0 next cycle, frame_cnt++ (wraps 0xFFFF→0), go to COLLECT.
  - Accept-to-next-beat bubble is 1 cycle. Minimum frame period is NUM_FEATURES+1 cycles.
- Latency: out_valid rises 1 cycle after the last beat transfers.
- frame_err is registered and high for exactly one cycle per dropped frame.
- out_data changes only on the COLLECT→FULL transition. Partially filled shadow slots are never visible on out_data.
- in_valid=0 cycles are allowed anywhere inside a frame; idx holds.
- rst asserted mid-frame or in FULL discards everything immediately. After rst is released, the first beat is treated as feature 0.

Decomposition:
- Shared package holds:
  - localparam VEC_W = NUM_FEATURES*Q_BITS.
  - State enum {COLLECT, FULL, DISCARD}.
  - A function computing the quantised code (shift, clamp, offset); the testbench model reuses it.
- One natural sub-module: layer0_feature_quantizer, purely combinational, IN_W→Q_BITS.
- The FSM, index counter and buffers stay in the top module.

Test Plan:
- Single frame, ramp in_data = k<<10 for k=0..31, out_ready=1: codes are 10 for k=0, 11 for k≥1; out_valid rises 1 cycle after beat 31; frame_cnt=1.
- Clamp and rounding with Q_BITS=2: in_data 0x8000→00, 0xFC00(-1024)→01, 0xFFFF→01, 0x03FF→10, 0x7FFF→11.
- Back-pressure: out_ready=0 for 20 cycles after out_valid. Required: in_ready=0, out_data stable, no beats accepted. Then out_ready=1 for one cycle → out_valid=0, in_ready=1 next cycle.
- Short frame: in_last on beat 5 → one-cycle frame_err, no out_valid. The next full 32-beat frame is delivered correctly.
- Long frame: 40 beats with in_last only on beat 39 → frame_err at beat 31, beats 32–39 discarded, no out_valid. The following frame is delivered; frame_cnt unchanged by the bad frame.
- Async rst pulse at beat 17 → out_valid=0 and idx=0 immediately. The next 32-beat frame packs correctly.
- frame_cnt preloaded near wrap (run 65536 frames) → frame_cnt=0.
